// File: rtl/reg_arb_if.sv
// rtl/reg_arb_if.sv - requester-side and downstream register bus signals of reg_arb
interface reg_arb_if #(
    parameter int DWIDTH = 8,
    parameter int AWIDTH = 8,
    parameter int NREQ   = 4
);
    logic [2*NREQ-1:0]      req_op;
    logic [NREQ*AWIDTH-1:0] req_addr;
    logic [NREQ*DWIDTH-1:0] req_wdata;
    logic [NREQ-1:0]        req_gnt;
    logic [NREQ-1:0]        req_rvalid;
    logic [DWIDTH-1:0]      req_rdata;
    logic [1:0]             m_op;
    logic [AWIDTH-1:0]      m_addr;
    logic [DWIDTH-1:0]      m_wdata;
    logic [DWIDTH-1:0]      m_rdata;

    // slave: the arbiter; master: requesters plus the downstream responder
    modport slave (
        input  req_op, req_addr, req_wdata, m_rdata,
        output req_gnt, req_rvalid, req_rdata, m_op, m_addr, m_wdata
    );
    modport master (
        output req_op, req_addr, req_wdata, m_rdata,
        input  req_gnt, req_rvalid, req_rdata, m_op, m_addr, m_wdata
    );
endinterface

// File: rtl/reg_arb.sv
// rtl/reg_arb.sv - N-requester round-robin register bus arbiter, one transaction in flight
// REG_ARB_FIXED_PRIO_EN selects fixed lowest-index priority instead of round-robin.
module reg_arb #(
    parameter int DWIDTH = 8,
    parameter int AWIDTH = 8,
    parameter int NREQ   = 4,
    parameter int RD_LAT = 1
) (
    input  logic     clk,
    input  logic     rst,
    reg_arb_if.slave bus
);
    localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam logic [1:0] OP_NOP = 2'b00;
    localparam logic [1:0] OP_RD  = 2'b01;
    localparam logic [1:0] OP_WR  = 2'b10;

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT} state_t;

    state_t              state_q, state_d;
    logic [3:0]          cnt_q, cnt_d;
    logic [PW-1:0]       win_q, win_d;
    logic [NREQ-1:0]     gnt_q, gnt_d;
    logic [NREQ-1:0]     rvalid_q, rvalid_d;
    logic [DWIDTH-1:0]   rdata_q, rdata_d;
    logic [1:0]          m_op_q, m_op_d;
    logic [AWIDTH-1:0]   m_addr_q, m_addr_d;
    logic [DWIDTH-1:0]   m_wdata_q, m_wdata_d;
`ifndef REG_ARB_FIXED_PRIO_EN
    logic [PW-1:0]       ptr_q, ptr_d;
`endif

    logic [NREQ-1:0]     active;
    logic                arb_found;
    logic [PW-1:0]       arb_idx;
    logic [1:0]          sel_op;
    logic [AWIDTH-1:0]   sel_addr;
    logic [DWIDTH-1:0]   sel_wdata;

    // Reserved op 11 never counts as a request
    always_comb begin
        for (int i = 0; i < NREQ; i++) begin
            active[i] = (bus.req_op[2*i +: 2] == OP_RD) || (bus.req_op[2*i +: 2] == OP_WR);
        end
    end

`ifdef REG_ARB_FIXED_PRIO_EN
    always_comb begin
        arb_found = 1'b0;
        arb_idx   = '0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            if (active[k]) begin
                arb_found = 1'b1;
                arb_idx   = PW'(k);
            end
        end
    end
`else
    // Scan downward so the last hit is the first active index at or after ptr
    always_comb begin
        logic [PW:0] cand;
        arb_found = 1'b0;
        arb_idx   = '0;
        cand      = '0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            cand = {1'b0, ptr_q} + (PW+1)'(k);
            if (cand >= (PW+1)'(NREQ)) begin
                cand = cand - (PW+1)'(NREQ);
            end
            if (active[cand[PW-1:0]]) begin
                arb_found = 1'b1;
                arb_idx   = cand[PW-1:0];
            end
        end
    end
`endif

    always_comb begin
        sel_op    = OP_NOP;
        sel_addr  = '0;
        sel_wdata = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (arb_idx == PW'(i)) begin
                sel_op    = bus.req_op[2*i +: 2];
                sel_addr  = bus.req_addr[AWIDTH*i +: AWIDTH];
                sel_wdata = bus.req_wdata[DWIDTH*i +: DWIDTH];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (arb_found) state_d = S_ISSUE;
            S_ISSUE: state_d = (m_op_q == OP_RD) ? S_WAIT : S_IDLE;
            S_WAIT:  if (cnt_q == 4'd1) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        cnt_d     = cnt_q;
        win_d     = win_q;
        gnt_d     = '0;
        rvalid_d  = '0;
        rdata_d   = rdata_q;
        m_op_d    = OP_NOP;
        m_addr_d  = m_addr_q;
        m_wdata_d = m_wdata_q;
`ifndef REG_ARB_FIXED_PRIO_EN
        ptr_d     = ptr_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (arb_found) begin
                    m_op_d    = sel_op;
                    m_addr_d  = sel_addr;
                    m_wdata_d = sel_wdata;
                    gnt_d     = NREQ'(1) << arb_idx;
                    win_d     = arb_idx;
`ifndef REG_ARB_FIXED_PRIO_EN
                    ptr_d     = (arb_idx == PW'(NREQ - 1)) ? '0 : arb_idx + 1'b1;
`endif
                end
            end
            S_ISSUE: begin
                if (m_op_q == OP_RD) begin
                    cnt_d = 4'(RD_LAT);
                end
            end
            S_WAIT: begin
                cnt_d = cnt_q - 1'b1;
                if (cnt_q == 4'd1) begin
                    rdata_d  = bus.m_rdata;
                    rvalid_d = NREQ'(1) << win_q;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q     <= '0;
            win_q     <= '0;
            gnt_q     <= '0;
            rvalid_q  <= '0;
            rdata_q   <= '0;
            m_op_q    <= OP_NOP;
            m_addr_q  <= '0;
            m_wdata_q <= '0;
`ifndef REG_ARB_FIXED_PRIO_EN
            ptr_q     <= '0;
`endif
        end else begin
            cnt_q     <= cnt_d;
            win_q     <= win_d;
            gnt_q     <= gnt_d;
            rvalid_q  <= rvalid_d;
            rdata_q   <= rdata_d;
            m_op_q    <= m_op_d;
            m_addr_q  <= m_addr_d;
            m_wdata_q <= m_wdata_d;
`ifndef REG_ARB_FIXED_PRIO_EN
            ptr_q     <= ptr_d;
`endif
        end
    end

    assign bus.req_gnt    = gnt_q;
    assign bus.req_rvalid = rvalid_q;
    assign bus.req_rdata  = rdata_q;
    assign bus.m_op       = m_op_q;
    assign bus.m_addr     = m_addr_q;
    assign bus.m_wdata    = m_wdata_q;
endmodule

// File: doc/reg_arb.md
# reg_arb

Parametrised N-requester arbiter for the register bus. Multiplexes NREQ independent requesters, each using the NOP/RD/WR operation encoding, onto one downstream register bus. Round-robin arbitration, one transaction in flight, configurable downstream read latency. Read data is routed back to the granted requester with a per-requester valid pulse. Sits between bus masters (CPU bridge, test sequencers, DMA) and a single register responder.

## Interface
Parameters:
- DWIDTH, 8, data width
- AWIDTH, 8, address width
- NREQ, 4, number of requesters, 1..16, need not be a power of two
- RD_LAT, 1, cycles from downstream RD issue to valid m_rdata, 1..15

Ports:
- clk  in  1  clock; the only clock
- rst  in  1  reset, synchronous, active-high
- req_op  in  2*NREQ  per-requester op; slice i = [2i+1:2i]; 00 NOP, 01 RD, 10 WR, 11 reserved (treated as NOP)
- req_addr  in  NREQ*AWIDTH  per-requester address, slice i
- req_wdata  in  NREQ*DWIDTH  per-requester write data, slice i
- req_gnt  out  NREQ  one-hot grant pulse
- req_rvalid  out  NREQ  one-hot read-data-valid pulse
- req_rdata  out  DWIDTH  read data, shared by all requesters, qualified by req_rvalid
- m_op  out  2  downstream op
- m_addr  out  AWIDTH  downstream address
- m_wdata  out  DWIDTH  downstream write data
- m_rdata  in  DWIDTH  downstream read data

## Operation
- Requester i is active when req_op slice i is RD or WR. It holds op/addr/wdata stable until the clock edge at which its req_gnt[i] is high, then may change them.
- FSM states: IDLE, ISSUE, WAIT.
- IDLE, any requester active: winner w = first active index at or after ptr, scanning upward and wrapping modulo NREQ.
  - At the edge, register m_op/m_addr/m_wdata from slice w and set req_gnt[w].
  - ptr <= (w+1) mod NREQ; go to ISSUE.
- IDLE, no active requester: m_op = NOP; stay in IDLE.
- ISSUE (exactly one cycle): m_op/m_addr/m_wdata valid and req_gnt[w] high. No arbitration in this state.
  - WR: next state IDLE.
  - RD: load latency counter with RD_LAT; next state WAIT.
- On leaving ISSUE: m_op returns to NOP and req_gnt clears. m_addr and m_wdata hold their last values.
- WAIT: decrement the counter each cycle. When it reaches 1, capture m_rdata at that edge into req_rdata, set req_rvalid[w] for one cycle, and return to IDLE.
- req_rdata holds its last captured value between reads.
- Reserved op 11 is never granted and never issued downstream.
- Arbitration in IDLE happens in the same cycle req_rvalid is high.
- Single requester (NREQ=1): ptr is constant 0.
- ptr width is max(1, $clog2(NREQ)).

## Timing
- Reset values, all synchronous:
  - state = IDLE, ptr = 0, counter = 0
  - req_gnt = 0, req_rvalid = 0, req_rdata = 0
  - m_op = NOP, m_addr = 0, m_wdata = 0
- rst has priority over every other event. rst during ISSUE or WAIT abandons the transaction: no req_rvalid is produced and the next grant starts scan from index 0.
- Request sampled at edge E: ISSUE (gnt + m_op) in cycle E+1.
- WR: next arbitration edge at end of cycle E+1. Sustained write throughput is one per 2 cycles.
- RD with m_op=RD in cycle T: m_rdata is sampled at the end of cycle T+RD_LAT. req_rvalid/req_rdata are valid in cycle T+RD_LAT+1.
- Read occupancy is RD_LAT+2 cycles per transaction.
- All outputs are registered. There is no combinational path from inputs to outputs.

## Configuration
- REG_ARB_FIXED_PRIO_EN defined: fixed priority; the lowest-index active requester always wins. ptr is not implemented and not updated.
- REG_ARB_FIXED_PRIO_EN undefined (default): round-robin as described above.

## Test plan
- Reset: drive random inputs with rst=1 for 3 cycles -> all outputs 0, m_op=NOP. First grant after release goes to the lowest active index.
- Single write: req 2 WR, addr 0x10, wdata 0xA5 -> req_gnt=4'b0100, m_op=WR, m_addr=0x10, m_wdata=0xA5 for exactly one cycle, one cycle after the request. No req_rvalid.
- Concurrent reads, RD_LAT=2, responder returning data = addr^0xFF: all 4 requesters RD at addrs 0x00..0x03 -> grants 0,1,2,3, spaced 4 cycles apart. Each req_rvalid[i] arrives 3 cycles after its ISSUE with rdata 0xFF, 0xFE, 0xFD, 0xFC.
- Fairness: requesters 1 and 3 issue continuous back-to-back WRs -> grant sequence 1,3,1,3,..., never two consecutive grants to the same requester. Repeat with REG_ARB_FIXED_PRIO_EN -> requester 1 always wins.
- Reset mid-read: RD_LAT=4, rst pulsed in the second WAIT cycle -> no req_rvalid. With requesters 0 and 3 active after release, req 0 is granted first.
- Reserved op: req 0 drives 11 and req 1 drives WR -> only req 1 is granted. After that, m_op stays NOP and req_gnt[0] never asserts.
